instr_fetch: RTL

- Fetch stage directly upstream of instruction decode.
- Owns the PC and issues word requests to instruction memory over a req/ready request channel and an rvalid response channel.
- Buffers returned instructions with their PCs and presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump target) with flush of stale in-flight responses, and a terminal halt.

---
 rtl/instr_fetch.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests, buffers responses for decode.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target halts fetch and raises o_misaligned.
module instr_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_halted
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        o_misaligned
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(BUF_DEPTH);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  logic [0:0]    state;
  logic [31:0]   pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] count;
  logic [CW-1:0] drop_cnt;

  logic [31:0]   pcq [BUF_DEPTH];
  logic [PW-1:0] pq_wr;
  logic [PW-1:0] pq_rd;

  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [PW-1:0] bf_wr;
  logic [PW-1:0] bf_rd;

  logic          run;
  logic          misalign;
  logic          halt_now;
  logic          redir_now;
  logic          flush;
  logic          req_int;
  logic          accept;
  logic          dropping;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;
  logic [31:0]   redirect_tgt;

  always_comb begin
    run = (state == S_RUN);
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign = |i_redirect_pc[1:0];
`else
    misalign = 1'b0;
`endif
    // Low target bits are dropped so the issued address always stays word aligned.
    redirect_tgt = i_redirect_pc & ~32'h3;
    halt_now     = run & (i_halt | (i_redirect & misalign));
    redir_now    = run & i_redirect & ~halt_now;
    flush        = halt_now | redir_now;
    occupancy    = {1'b0, inflight} + {1'b0, count};
    req_int      = run & ~i_redirect & ~i_halt & (occupancy < DEPTH_W);
    accept       = req_int & i_imem_ready;
    dropping     = i_imem_rvalid & (drop_cnt != '0);
    push         = i_imem_rvalid & ~dropping & run & ~flush;
    pop          = (count != '0) & i_ready & run & ~flush;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state    <= S_RUN;
      pc       <= {RESET_ADDR[31:2], 2'b00};
      inflight <= '0;
      count    <= '0;
      drop_cnt <= '0;
      pq_wr    <= '0;
      pq_rd    <= '0;
      bf_wr    <= '0;
      bf_rd    <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(i_imem_rvalid);
      if (accept)        pq_wr <= ptr_inc(pq_wr);
      if (i_imem_rvalid) pq_rd <= ptr_inc(pq_rd);
      if (halt_now)      state <= S_HALTED;
      if (redir_now)     pc <= redirect_tgt;
      else if (accept)   pc <= pc + 32'd4;
      if (flush) begin
        // Everything still outstanding after this cycle's response is stale.
        drop_cnt <= inflight - CW'(i_imem_rvalid);
        count    <= '0;
        bf_wr    <= '0;
        bf_rd    <= '0;
      end else begin
        if (dropping) drop_cnt <= drop_cnt - CW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (push) bf_wr <= ptr_inc(bf_wr);
        if (pop)  bf_rd <= ptr_inc(bf_rd);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) pcq[pq_wr] <= pc;
    if (push) begin
      buf_instr[bf_wr] <= i_imem_rdata;
      buf_pc[bf_wr]    <= pcq[pq_rd];
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst)                                      o_misaligned <= 1'b0;
    else if (run & i_redirect & misalign & ~i_halt)  o_misaligned <= 1'b1;
  end
`endif

  assign o_imem_req  = i_rst & req_int;
  assign o_imem_addr = pc;
  assign o_valid     = i_rst & run & (count != '0);
  assign o_instr     = buf_instr[bf_rd];
  assign o_pc        = buf_pc[bf_rd];
  assign o_halted    = i_rst & (state == S_HALTED);

  rvalid_needs_inflight: assert property (@(posedge i_clk) disable iff (!i_rst)
    !(i_imem_rvalid && (inflight == '0)));

endmodule
